// File: rtl/pong_pkg.sv
// Shared types for the pong link message scheduler: message type encoding,
// scheduler states and the payload record carried by every message.
package pong_pkg;

  localparam int BALL_Y_W = 9;
  localparam int VEL_W    = 4;
  localparam int SCORE_W  = 5;

  typedef enum logic [3:0] {
    MSG_NONE         = 4'b0000,
    MSG_BALL         = 4'b0001,
    MSG_MISS         = 4'b0010,
    MSG_NEW_GAME     = 4'b0100,
    MSG_NEW_GAME_ACK = 4'b1000
  } msg_type_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    AWAIT_ACK,
    SEND_NESTED
  } sched_state_t;

  typedef struct packed {
    logic [BALL_Y_W-1:0] ball_y;
    logic [VEL_W-1:0]    velocity_x;
    logic [VEL_W-1:0]    velocity_y;
    logic                sign_y;
    logic [SCORE_W-1:0]  my_score;
    logic [SCORE_W-1:0]  your_score;
    logic                you_should_serve;
    logic                you_serve_first;
  } payload_t;

endpackage

// File: rtl/msg_tx_scheduler_ack_timer.sv
// Acknowledgement timer: counts while enabled, holds its value when not,
// and flags the last cycle of the timeout window.
module ack_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int WIDTH          = 22
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] count;

  // Clear has priority over counting so a fresh wait always starts at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/msg_tx_scheduler.sv
// Transmit scheduler for the pong link: arbitrates four message requesters,
// hands one message at a time to the serial sender, and runs the new-game
// handshake with timeout, retransmission and link status tracking.
module msg_tx_scheduler
  import pong_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ball_req,
  input  logic                miss_req,
  input  logic                new_game_req,
  input  logic                new_game_ack_req,
  output logic                ball_gnt,
  output logic                miss_gnt,
  output logic                new_game_gnt,
  output logic                new_game_ack_gnt,
  input  logic [BALL_Y_W-1:0] ball_y_in,
  input  logic [VEL_W-1:0]    velocity_x_in,
  input  logic [VEL_W-1:0]    velocity_y_in,
  input  logic                sign_y_in,
  input  logic [SCORE_W-1:0]  my_score_in,
  input  logic [SCORE_W-1:0]  your_score_in,
  input  logic                you_should_serve_in,
  input  logic                you_serve_first_in,
  input  logic                new_game_ack_seen,
  output logic                send_new_message,
  input  logic                message_sent,
  output logic [BALL_Y_W-1:0] ball_y_tx,
  output logic [VEL_W-1:0]    velocity_x_tx,
  output logic [VEL_W-1:0]    velocity_y_tx,
  output logic                sign_y_tx,
  output logic [SCORE_W-1:0]  my_score_tx,
  output logic [SCORE_W-1:0]  your_score_tx,
  output logic                you_should_serve_tx,
  output logic                you_serve_first_tx,
  output logic                ball_message_tx,
  output logic                miss_message_tx,
  output logic                new_game_message_tx,
  output logic                new_game_ack_message_tx,
  output logic                link_up,
  output logic                link_error,
  output logic                busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  sched_state_t       state, state_next;
  msg_type_t          gnt_sel, tx_type;
  payload_t           in_payload, tx_payload, ng_payload;
  logic [RETRY_W-1:0] retries;
  logic               timer_clear, timer_en, timer_done;
  logic               retry_inc, set_link_up, set_error, restore;

  assign in_payload = '{
    ball_y:           ball_y_in,
    velocity_x:       velocity_x_in,
    velocity_y:       velocity_y_in,
    sign_y:           sign_y_in,
    my_score:         my_score_in,
    your_score:       your_score_in,
    you_should_serve: you_should_serve_in,
    you_serve_first:  you_serve_first_in
  };

  ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WIDTH         (TIMER_W)
  ) u_ack_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .terminal(timer_done)
  );

  // Scheduler state register; reset drops any message in flight at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and handshake decisions; an ack seen wins over a timeout,
  // and the timer is frozen on the nested grant cycle and during the nested send.
  always_comb begin
    state_next  = state;
    gnt_sel     = MSG_NONE;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    retry_inc   = 1'b0;
    set_link_up = 1'b0;
    set_error   = 1'b0;
    restore     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (new_game_ack_req)  gnt_sel = MSG_NEW_GAME_ACK;
          else if (new_game_req) gnt_sel = MSG_NEW_GAME;
          else if (miss_req)     gnt_sel = MSG_MISS;
          else if (ball_req)     gnt_sel = MSG_BALL;
          if (gnt_sel != MSG_NONE) state_next = SEND;
        end
      end
      SEND: begin
        if (message_sent) begin
          if (tx_type == MSG_NEW_GAME) begin
            state_next  = AWAIT_ACK;
            timer_clear = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      AWAIT_ACK: begin
        if (new_game_ack_seen) begin
          set_link_up = 1'b1;
          state_next  = IDLE;
        end else if (timer_done) begin
          if (retries < RETRY_W'(MAX_RETRIES)) begin
            retry_inc  = 1'b1;
            state_next = SEND;
          end else begin
            set_error  = 1'b1;
            state_next = IDLE;
          end
        end else if (new_game_ack_req) begin
          gnt_sel    = MSG_NEW_GAME_ACK;
          state_next = SEND_NESTED;
        end else begin
          timer_en = 1'b1;
        end
      end
      SEND_NESTED: begin
        if (message_sent) begin
          restore    = 1'b1;
          state_next = AWAIT_ACK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Message register: captured on each grant, and put back to the saved
  // new-game message once a nested acknowledgement has gone out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_payload <= '0;
      ng_payload <= '0;
      tx_type    <= MSG_NONE;
    end else begin
      if (gnt_sel != MSG_NONE) begin
        tx_payload <= in_payload;
        tx_type    <= gnt_sel;
      end
      if (gnt_sel == MSG_NEW_GAME) begin
        ng_payload <= in_payload;
      end
      if (restore) begin
        tx_payload <= ng_payload;
        tx_type    <= MSG_NEW_GAME;
      end
    end
  end

  // Link status and retry bookkeeping; link_error stays set until a new game starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retries    <= '0;
      link_up    <= 1'b0;
      link_error <= 1'b0;
    end else begin
      if (gnt_sel == MSG_NEW_GAME) begin
        retries    <= '0;
        link_up    <= 1'b0;
        link_error <= 1'b0;
      end
      if (retry_inc) begin
        retries <= retries + RETRY_W'(1);
      end
      if (set_link_up) begin
        retries    <= '0;
        link_up    <= 1'b1;
        link_error <= 1'b0;
      end
      if (set_error) begin
        link_up    <= 1'b0;
        link_error <= 1'b1;
      end
    end
  end

  assign ball_gnt         = (gnt_sel == MSG_BALL);
  assign miss_gnt         = (gnt_sel == MSG_MISS);
  assign new_game_gnt     = (gnt_sel == MSG_NEW_GAME);
  assign new_game_ack_gnt = (gnt_sel == MSG_NEW_GAME_ACK);

  assign send_new_message = (state == SEND) || (state == SEND_NESTED);
  assign busy             = (state != IDLE);

  assign ball_y_tx           = tx_payload.ball_y;
  assign velocity_x_tx       = tx_payload.velocity_x;
  assign velocity_y_tx       = tx_payload.velocity_y;
  assign sign_y_tx           = tx_payload.sign_y;
  assign my_score_tx         = tx_payload.my_score;
  assign your_score_tx       = tx_payload.your_score;
  assign you_should_serve_tx = tx_payload.you_should_serve;
  assign you_serve_first_tx  = tx_payload.you_serve_first;

  assign ball_message_tx         = (tx_type == MSG_BALL);
  assign miss_message_tx         = (tx_type == MSG_MISS);
  assign new_game_message_tx     = (tx_type == MSG_NEW_GAME);
  assign new_game_ack_message_tx = (tx_type == MSG_NEW_GAME_ACK);

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Self-checking bench for msg_tx_scheduler: a priority table, hand-written
// handshake/reset sequences and randomized request traffic checked against
// a simple pending-request model.
module tb_msg_tx_scheduler;

  localparam int TIMEOUT = 8;
  localparam int RETRIES = 2;

  logic       clock, reset;
  logic       ball_req, miss_req, new_game_req, new_game_ack_req;
  logic       ball_gnt, miss_gnt, new_game_gnt, new_game_ack_gnt;
  logic [8:0] ball_y_in;
  logic [3:0] velocity_x_in, velocity_y_in;
  logic       sign_y_in;
  logic [4:0] my_score_in, your_score_in;
  logic       you_should_serve_in, you_serve_first_in;
  logic       new_game_ack_seen, send_new_message, message_sent;
  logic [8:0] ball_y_tx;
  logic [3:0] velocity_x_tx, velocity_y_tx;
  logic       sign_y_tx;
  logic [4:0] my_score_tx, your_score_tx;
  logic       you_should_serve_tx, you_serve_first_tx;
  logic       ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx;
  logic       link_up, link_error, busy;

  int         compared;
  int         mismatched;
  logic [3:0] pend;

  typedef struct {
    logic [3:0] req;
    int         lat;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t vectors[7];

  int  sends, gnts, gap, lowc, extra;
  bit  prev, started, done;

  msg_tx_scheduler #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES   (RETRIES)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .ball_req               (ball_req),
    .miss_req               (miss_req),
    .new_game_req           (new_game_req),
    .new_game_ack_req       (new_game_ack_req),
    .ball_gnt               (ball_gnt),
    .miss_gnt               (miss_gnt),
    .new_game_gnt           (new_game_gnt),
    .new_game_ack_gnt       (new_game_ack_gnt),
    .ball_y_in              (ball_y_in),
    .velocity_x_in          (velocity_x_in),
    .velocity_y_in          (velocity_y_in),
    .sign_y_in              (sign_y_in),
    .my_score_in            (my_score_in),
    .your_score_in          (your_score_in),
    .you_should_serve_in    (you_should_serve_in),
    .you_serve_first_in     (you_serve_first_in),
    .new_game_ack_seen      (new_game_ack_seen),
    .send_new_message       (send_new_message),
    .message_sent           (message_sent),
    .ball_y_tx              (ball_y_tx),
    .velocity_x_tx          (velocity_x_tx),
    .velocity_y_tx          (velocity_y_tx),
    .sign_y_tx              (sign_y_tx),
    .my_score_tx            (my_score_tx),
    .your_score_tx          (your_score_tx),
    .you_should_serve_tx    (you_should_serve_tx),
    .you_serve_first_tx     (you_serve_first_tx),
    .ball_message_tx        (ball_message_tx),
    .miss_message_tx        (miss_message_tx),
    .new_game_message_tx    (new_game_message_tx),
    .new_game_ack_message_tx(new_game_ack_message_tx),
    .link_up                (link_up),
    .link_error             (link_error),
    .busy                   (busy)
  );

  // Free-running 100 MHz bench clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the design never returns to a state the bench waits for.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    {new_game_ack_req, new_game_req, miss_req, ball_req} = pend;
  endtask

  task automatic randomizePayload();
    ball_y_in           = 9'($urandom);
    velocity_x_in       = 4'($urandom);
    velocity_y_in       = 4'($urandom);
    sign_y_in           = 1'($urandom);
    my_score_in         = 5'($urandom);
    your_score_in       = 5'($urandom);
    you_should_serve_in = 1'($urandom);
    you_serve_first_in  = 1'($urandom);
  endtask

  function automatic logic [3:0] expectedGrant(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  // Starts at posedge+1 of an IDLE cycle with requests driven; ends at
  // posedge+1 of the next IDLE cycle.
  task automatic runTransaction(input logic [3:0] exp_gnt, input int lat, input int ackd, input bit drop_all);
    logic [8:0] cap_y;
    logic [3:0] cap_vx;
    logic [4:0] cap_my;
    logic       cap_sf;
    bit         is_ng;
    is_ng = (exp_gnt == 4'b0100);
    @(negedge clock);
    checkOutput("grant", 32'({new_game_ack_gnt, new_game_gnt, miss_gnt, ball_gnt}), 32'(exp_gnt));
    checkOutput("busy_in_idle", 32'(busy), 0);
    cap_y  = ball_y_in;
    cap_vx = velocity_x_in;
    cap_my = my_score_in;
    cap_sf = you_serve_first_in;
    @(posedge clock); #1;
    if (drop_all) pend = 4'b0000;
    else pend = pend & ~exp_gnt;
    applyStimulus();
    randomizePayload();
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      message_sent = (c == lat);
      @(negedge clock);
      checkOutput("send_level", 32'(send_new_message), 1);
      checkOutput("no_gnt_in_send", 32'({new_game_ack_gnt, new_game_gnt, miss_gnt, ball_gnt}), 0);
      if (c == 0) begin
        checkOutput("type_flags", 32'({new_game_ack_message_tx, new_game_message_tx, miss_message_tx, ball_message_tx}), 32'(exp_gnt));
        checkOutput("ball_y_tx", 32'(ball_y_tx), 32'(cap_y));
        checkOutput("velocity_x_tx", 32'(velocity_x_tx), 32'(cap_vx));
        checkOutput("my_score_tx", 32'(my_score_tx), 32'(cap_my));
        checkOutput("you_serve_first_tx", 32'(you_serve_first_tx), 32'(cap_sf));
        if (is_ng) begin
          checkOutput("ng_clears_link", 32'({link_up, link_error}), 0);
        end
      end
    end
    @(posedge clock); #1;
    message_sent = 1'b0;
    if (is_ng) begin
      for (int d = 0; d <= ackd; d++) begin
        new_game_ack_seen = (d == ackd);
        @(negedge clock);
        checkOutput("await_quiet", 32'({send_new_message, miss_gnt, ball_gnt}), 0);
        @(posedge clock); #1;
      end
      new_game_ack_seen = 1'b0;
      checkOutput("link_up_after_ack", 32'(link_up), 1);
    end
    checkOutput("send_dropped", 32'(send_new_message), 0);
    checkOutput("busy_back_idle", 32'(busy), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    vectors[0] = '{4'b0001, 0, 4'b0001};
    vectors[1] = '{4'b0010, 1, 4'b0010};
    vectors[2] = '{4'b0011, 2, 4'b0010};
    vectors[3] = '{4'b0110, 0, 4'b0100};
    vectors[4] = '{4'b1111, 1, 4'b1000};
    vectors[5] = '{4'b1001, 3, 4'b1000};
    vectors[6] = '{4'b0101, 0, 4'b0100};

    reset = 1'b1;
    message_sent = 1'b0;
    new_game_ack_seen = 1'b0;
    pend = 4'b1111;
    applyStimulus();
    randomizePayload();
    repeat (3) @(posedge clock);
    #1;
    $display("[TB] reset state");
    checkOutput("reset_grants", 32'({new_game_ack_gnt, new_game_gnt, miss_gnt, ball_gnt}), 0);
    checkOutput("reset_status", 32'({send_new_message, busy, link_up, link_error}), 0);
    checkOutput("reset_types", 32'({new_game_ack_message_tx, new_game_message_tx, miss_message_tx, ball_message_tx}), 0);
    checkOutput("reset_payload", 32'({ball_y_tx, my_score_tx, your_score_tx}), 0);
    pend = 4'b0000;
    applyStimulus();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    $display("[TB] priority table");
    for (int i = 0; i < 7; i++) begin
      pend = vectors[i].req;
      randomizePayload();
      applyStimulus();
      runTransaction(vectors[i].exp_gnt, vectors[i].lat, 2, 1'b1);
    end

    $display("[TB] ball message with three-cycle send");
    pend = 4'b0001;
    randomizePayload();
    ball_y_in = 9'd200;
    applyStimulus();
    runTransaction(4'b0001, 2, 0, 1'b0);
    checkOutput("ball_y_200", 32'(ball_y_tx), 200);

    $display("[TB] miss before ball");
    pend = 4'b0011;
    randomizePayload();
    applyStimulus();
    runTransaction(4'b0010, 1, 0, 1'b0);
    runTransaction(4'b0001, 0, 0, 1'b0);

    $display("[TB] new game acked after 5 cycles");
    pend = 4'b0100;
    randomizePayload();
    applyStimulus();
    runTransaction(4'b0100, 0, 5, 1'b0);
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (send_new_message || busy) extra++;
    end
    @(posedge clock); #1;
    checkOutput("no_retransmit", extra, 0);

    $display("[TB] ack and timeout in the same cycle");
    pend = 4'b0100;
    randomizePayload();
    applyStimulus();
    runTransaction(4'b0100, 0, TIMEOUT - 1, 1'b0);

    $display("[TB] nested ack inside new-game wait");
    pend = 4'b0100;
    randomizePayload();
    my_score_in = 5'd9;
    your_score_in = 5'd3;
    applyStimulus();
    @(negedge clock);
    checkOutput("nest_ng_gnt", 32'(new_game_gnt), 1);
    @(posedge clock); #1;
    pend = 4'b0000;
    applyStimulus();
    message_sent = 1'b1;
    @(negedge clock);
    checkOutput("nest_ng_send", 32'(send_new_message), 1);
    @(posedge clock); #1;
    message_sent = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    pend = 4'b1000;
    applyStimulus();
    my_score_in = 5'd21;
    @(negedge clock);
    checkOutput("nest_ack_gnt", 32'(new_game_ack_gnt), 1);
    @(posedge clock); #1;
    pend = 4'b0000;
    applyStimulus();
    my_score_in = 5'd0;
    message_sent = 1'b1;
    @(negedge clock);
    checkOutput("nest_ack_send", 32'({send_new_message, new_game_ack_message_tx, new_game_message_tx}), 32'(3'b110));
    checkOutput("nest_ack_score", 32'(my_score_tx), 21);
    @(posedge clock); #1;
    message_sent = 1'b0;
    lowc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (send_new_message) break;
      lowc++;
      @(posedge clock); #1;
    end
    checkOutput("nest_resume_cycles", lowc, TIMEOUT - 4);
    checkOutput("nest_restored_type", 32'({new_game_ack_message_tx, new_game_message_tx}), 32'(2'b01));
    checkOutput("nest_restored_scores", 32'({my_score_tx, your_score_tx}), 32'({5'd9, 5'd3}));
    @(posedge clock); #1;
    message_sent = 1'b1;
    @(posedge clock); #1;
    message_sent = 1'b0;
    new_game_ack_seen = 1'b1;
    @(posedge clock); #1;
    new_game_ack_seen = 1'b0;
    checkOutput("nest_link_up", 32'({link_up, busy}), 32'(2'b10));

    $display("[TB] new game never acknowledged");
    pend = 4'b0100;
    randomizePayload();
    applyStimulus();
    message_sent = 1'b1;
    sends = 0; gnts = 0; gap = 0; prev = 0; started = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clock);
      if (new_game_gnt) gnts++;
      if (send_new_message) begin
        if (!prev) begin
          sends++;
          if (sends > 1) checkOutput("retry_gap", gap, TIMEOUT);
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev = send_new_message;
      if (busy) started = 1;
      else if (started) done = 1;
      @(posedge clock); #1;
      pend = 4'b0000;
      applyStimulus();
    end
    message_sent = 1'b0;
    checkOutput("error_reached_idle", 32'(done), 1);
    checkOutput("ng_grant_count", gnts, 1);
    checkOutput("ng_send_count", sends, RETRIES + 1);
    checkOutput("link_error_set", 32'({link_error, link_up, busy}), 32'(3'b100));

    $display("[TB] reset in the middle of a message");
    pend = 4'b0001;
    randomizePayload();
    ball_y_in = 9'd77;
    applyStimulus();
    @(negedge clock);
    checkOutput("pre_reset_gnt", 32'(ball_gnt), 1);
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("pre_reset_send", 32'(send_new_message), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_status", 32'({send_new_message, busy, link_up, link_error, ball_gnt}), 0);
    checkOutput("async_reset_payload", 32'({ball_y_tx, ball_message_tx}), 0);
    @(posedge clock);
    @(posedge clock); #1;
    checkOutput("no_gnt_in_reset", 32'(ball_gnt), 0);
    reset = 1'b0;
    #1;
    checkOutput("gnt_after_release", 32'(ball_gnt), 1);
    @(posedge clock); #1;
    pend = 4'b0000;
    applyStimulus();
    message_sent = 1'b1;
    @(posedge clock); #1;
    message_sent = 1'b0;
    checkOutput("post_reset_ball_y", 32'(ball_y_tx), 77);
    checkOutput("post_reset_idle", 32'(busy), 0);

    $display("[TB] randomized traffic");
    pend = 4'b0000;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
      end
      if (pend == 4'b0000) pend[0] = 1'b1;
      randomizePayload();
      applyStimulus();
      runTransaction(expectedGrant(pend), int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 2)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
